// File: rtl/fp_mul_pkg.sv
// Shared FP32 multiply types and widths, used by the sequential front end and the normalize stage.
package fp_mul_pkg;

  localparam int unsigned EXP_W     = 8;
  localparam int unsigned MANT_W    = 24;
  localparam int unsigned FRAC_W    = 23;
  localparam int unsigned BIAS      = 127;
  localparam int unsigned PROD_W    = 2 * MANT_W;
  localparam int unsigned EXP_SUM_W = EXP_W + 1;
  localparam int unsigned CNT_W     = $clog2(MANT_W);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fp_mul_seq_front_if.sv
// Operand-in / unnormalized-result-out handshake bundle of the sequential FP32 multiply front end.
interface fp_mul_seq_front_if;
  import fp_mul_pkg::*;

  logic              in_valid;
  logic              in_ready;
  fp32_t             a;
  fp32_t             b;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [PROD_W-1:0] out_mant;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant
  );

endinterface

// File: rtl/mant_shift_add_mul.sv
// Radix-2 shift-and-add significand multiplier: one partial product per step, MANT_W steps per product.
module mant_shift_add_mul
  import fp_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic [FRAC_W-1:0] a_frac,
  input  logic [FRAC_W-1:0] b_frac,
  output logic [PROD_W-1:0] acc,
  output logic              done_c
);

  logic [PROD_W-1:0] mcand;
  logic [MANT_W-1:0] mplr;
  logic [CNT_W-1:0]  count;

  // Hidden bit is forced to 1; exceptional encodings are left to downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      count <= '0;
    end else if (start) begin
      acc   <= '0;
      mcand <= {{(PROD_W-MANT_W){1'b0}}, 1'b1, a_frac};
      mplr  <= {1'b1, b_frac};
      count <= '0;
    end else if (step) begin
      if (mplr[0]) begin
        acc <= acc + mcand;
      end
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      count <= count + CNT_W'(1);
    end
  end

  assign done_c = step && (count == CNT_W'(MANT_W - 1));

endmodule

// File: rtl/fp_mul_seq_front.sv
// Sequential FP32 multiply front end: sign/exponent registers, handshake FSM and the iterative mantissa core.
module fp_mul_seq_front
  import fp_mul_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fp_mul_seq_front_if.slave  bus,
  output logic               busy
);

  state_t                 state_q;
  state_t                 state_d;
  logic                   load_c;
  logic                   done_c;
  logic                   out_sign_q;
  logic [EXP_W-1:0]       out_exp_q;
  logic [PROD_W-1:0]      acc;
  logic [EXP_SUM_W-1:0]   exp_sum_c;

  // Biased exponent wraps modulo 2^EXP_W; no overflow/underflow flagging here.
  assign exp_sum_c = {1'b0, bus.a.exp} + {1'b0, bus.b.exp} - EXP_SUM_W'(BIAS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && !rst) begin
          load_c  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (done_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_sign_q <= 1'b0;
      out_exp_q  <= '0;
    end else if (load_c) begin
      out_sign_q <= bus.a.sign ^ bus.b.sign;
      out_exp_q  <= EXP_W'(exp_sum_c);
    end
  end

  mant_shift_add_mul u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (load_c),
    .step   (state_q == CALC),
    .a_frac (bus.a.frac),
    .b_frac (bus.b.frac),
    .acc    (acc),
    .done_c (done_c)
  );

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE) && !rst;
  assign bus.out_sign  = out_sign_q;
  assign bus.out_exp   = out_exp_q;
  assign bus.out_mant  = acc;
  assign busy          = (state_q != IDLE) && !rst;

endmodule

// File: tb/tb_fp_mul_seq_front.sv
// Scoreboard bench for fp_mul_seq_front: directed spec vectors, backpressure, reset abort, random ops.
module tb_fp_mul_seq_front;
  import fp_mul_pkg::*;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [47:0] mant;
  } sb_t;

  logic clk;
  logic rst;
  logic busy;
  int   n_checks;
  int   n_pass;
  sb_t  sbq[$];

  fp_mul_seq_front_if bus ();

  fp_mul_seq_front dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic sb_t model(input logic [31:0] av, input logic [31:0] bv);
    sb_t         r;
    logic [47:0] ma;
    logic [47:0] mb;
    logic [9:0]  es;
    ma     = {24'b0, 1'b1, av[22:0]};
    mb     = {24'b0, 1'b1, bv[22:0]};
    es     = 10'(av[30:23]) + 10'(bv[30:23]) - 10'd127;
    r.sign = av[31] ^ bv[31];
    r.exp  = es[7:0];
    r.mant = ma * mb;
    return r;
  endfunction

  task automatic compare_front(input string tag);
    if (sbq.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sbq.size()), 64'd1);
    end else begin
      check({tag, "_sign"}, 64'(bus.out_sign), 64'(sbq[0].sign));
      check({tag, "_exp"},  64'(bus.out_exp),  64'(sbq[0].exp));
      check({tag, "_mant"}, 64'(bus.out_mant), 64'(sbq[0].mant));
    end
  endtask

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input sb_t want,
                        input int hold, input bit junk);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    tick();
    sbq.push_back(want);
    bus.in_valid = 1'b0;
    check("busy_calc", 64'(busy), 64'd1);
    check("in_ready_calc", 64'(bus.in_ready), 64'd0);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      if (junk) begin
        bus.in_valid = 1'b1;
        bus.a        = $urandom;
        bus.b        = $urandom;
      end
      tick();
      n++;
    end
    check("latency", 64'(n), 64'(MANT_W));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = $urandom;
      bus.b        = $urandom;
      tick();
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      compare_front("hold");
    end
    bus.in_valid = 1'b0;
    compare_front("result");
    if (sbq.size() != 0) void'(sbq.pop_front());
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("post_xfer_valid", 64'(bus.out_valid), 64'd0);
    check("post_xfer_in_ready", 64'(bus.in_ready), 64'd1);
    check("post_xfer_busy", 64'(busy), 64'd0);
  endtask

  function automatic sb_t mk(input logic s, input logic [7:0] e, input logic [47:0] m);
    sb_t r;
    r.sign = s;
    r.exp  = e;
    r.mant = m;
    return r;
  endfunction

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          seen;
    n_checks      = 0;
    n_pass        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (2) tick();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sign", 64'(bus.out_sign), 64'd0);
    check("rst_exp", 64'(bus.out_exp), 64'd0);
    check("rst_mant", 64'(bus.out_mant), 64'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);

    run_op(32'h3FC00000, 32'h40000000, mk(1'b0, 8'h80, 48'h600000000000), 0, 1'b0);
    run_op(32'hBF800000, 32'h3F800000, mk(1'b1, 8'h7F, 48'h400000000000), 0, 1'b0);
    run_op(32'h3FFFFFFF, 32'h3FFFFFFF, mk(1'b0, 8'h7F, 48'hFFFFFE000001), 0, 1'b0);
    run_op(32'h7F000000, 32'h7F000000, mk(1'b0, 8'h7D, 48'h400000000000), 0, 1'b0);
    run_op(32'h00800000, 32'h00800000, mk(1'b0, 8'h83, 48'h400000000000), 0, 1'b0);
    run_op(32'h3FC00000, 32'h40000000, mk(1'b0, 8'h80, 48'h600000000000), 10, 1'b1);

    // Abort: reset lands on the 10th CALC edge, nothing may emerge afterwards.
    bus.in_valid = 1'b1;
    bus.a        = 32'h3FC00000;
    bus.b        = 32'h40000000;
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    check("abort_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(bus.in_ready), 64'd0);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.out_valid || busy) seen++;
    end
    check("abort_no_output", 64'(seen), 64'd0);
    run_op(32'h3FC00000, 32'h40000000, mk(1'b0, 8'h80, 48'h600000000000), 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op(ra, rb, model(ra, rb), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
